// File: rtl/computer_pkg.sv
// Shared definitions for the 8-bit accumulator computer: widths, opcodes
// and the instruction phase encoding seen on icycle.
package computer_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_DECODE  = 2'd1,
        PH_EXECUTE = 2'd2,
        PH_HALT    = 2'd3
    } phase_t;

endpackage

// File: rtl/computer_mem.sv
// 16x8 unified program/data RAM with synchronous read and write, cleared to
// zero at time zero.
module computer_mem #(
    parameter INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);
    import computer_pkg::*;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/computer_core.sv
// Three-phase accumulator CPU: FETCH / DECODE / EXECUTE with an absorbing
// HALT, driving all architectural state onto ports.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_FETCH   | memory address = pc
//   S_DECODE  | ir <- mem data, pc <- pc+1, operand address = new ir[3:0]
//   S_EXECUTE | commit result to acc/flags/pc/mem/out_port
//   S_HALT    | all registers hold until reset
module computer_core #(
    parameter INIT_FILE = "program.hex"
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] icycle,
    output logic [3:0] pc,
    output logic [7:0] acc,
    output logic [7:0] ir,
    output logic [7:0] out_port,
    output logic       zero,
    output logic       carry,
    output logic       halted
);
    import computer_pkg::*;

    localparam logic [1:0] S_FETCH   = PH_FETCH;
    localparam logic [1:0] S_DECODE  = PH_DECODE;
    localparam logic [1:0] S_EXECUTE = PH_EXECUTE;
    localparam logic [1:0] S_HALT    = PH_HALT;

    logic [1:0] state;
    logic [3:0] raddr;
    logic [7:0] rdata;
    logic       we;
    logic [3:0] opcode;
    logic [8:0] sum;
    logic [8:0] diff;

    assign opcode = ir[7:4];
    assign sum    = {1'b0, acc} + {1'b0, rdata};
    assign diff   = {1'b0, acc} - {1'b0, rdata};

    // In DECODE ir is still loading, so the operand address comes straight
    // from the word just fetched.
    always_comb begin
        raddr = ir[3:0];
        case (state)
            S_FETCH:  raddr = pc;
            S_DECODE: raddr = rdata[3:0];
            default:  raddr = ir[3:0];
        endcase
    end

    assign we = (state == S_EXECUTE) && (opcode == OP_STA) && !reset;

    computer_mem #(
        .INIT_FILE(INIT_FILE)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(ir[3:0]),
        .wdata(acc),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= '0;
            acc      <= '0;
            ir       <= '0;
            out_port <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir    <= rdata;
                    pc    <= pc + 4'd1;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    state <= (opcode == OP_HLT) ? S_HALT : S_FETCH;
                    case (opcode)
                        OP_LDA: begin
                            acc  <= rdata;
                            zero <= (rdata == 8'd0);
                        end
                        OP_ADD: begin
                            acc   <= sum[7:0];
                            carry <= sum[8];
                            zero  <= (sum[7:0] == 8'd0);
                        end
                        OP_SUB: begin
                            acc   <= diff[7:0];
                            carry <= diff[8];
                            zero  <= (diff[7:0] == 8'd0);
                        end
                        OP_LDI: begin
                            acc  <= {4'b0, ir[3:0]};
                            zero <= (ir[3:0] == 4'd0);
                        end
                        OP_JMP: pc <= ir[3:0];
                        OP_JZ:  if (zero)  pc <= ir[3:0];
                        OP_JC:  if (carry) pc <= ir[3:0];
                        OP_OUT: out_port <= acc;
                        default: ;
                    endcase
                end
                default: state <= S_HALT;
            endcase
        end
    end

    assign icycle = state;
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_computer_core.sv
// Bench for computer_core: directed programs plus random memory images run
// against an instruction-level model of the accumulator machine.
module tb_computer_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] icycle;
    logic [3:0] pc;
    logic [7:0] acc;
    logic [7:0] ir;
    logic [7:0] out_port;
    logic       zero;
    logic       carry;
    logic       halted;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_mem [16];
    logic [3:0] m_pc;
    logic [7:0] m_acc;
    logic [7:0] m_out;
    logic       m_z;
    logic       m_c;
    logic       m_halt;

    computer_core #(
        .INIT_FILE("")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .icycle  (icycle),
        .pc      (pc),
        .acc     (acc),
        .ir      (ir),
        .out_port(out_port),
        .zero    (zero),
        .carry   (carry),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // One whole instruction, ISA-level semantics.
    function automatic void model_step();
        logic [7:0] instr;
        int op, n, a, v, s;
        if (m_halt) return;
        instr = m_mem[m_pc];
        m_pc  = m_pc + 4'd1;
        op    = int'(instr) / 16;
        n     = int'(instr) % 16;
        a     = int'(m_acc);
        v     = int'(m_mem[n]);
        case (op)
            1: begin m_acc = 8'(v); m_z = (v == 0); end
            2: begin s = a + v; m_c = (s > 255); m_acc = 8'(s % 256); m_z = (m_acc == 8'd0); end
            3: begin m_c = (a < v); s = (a - v + 256) % 256; m_acc = 8'(s); m_z = (s == 0); end
            4: m_mem[n] = m_acc;
            5: begin m_acc = 8'(n); m_z = (n == 0); end
            6: m_pc = 4'(n);
            7: if (m_z) m_pc = 4'(n);
            8: if (m_c) m_pc = 4'(n);
            14: m_out = m_acc;
            15: m_halt = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic clear_image();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    endtask

    // Hold reset, copy the image into the DUT RAM, release on a falling edge.
    task automatic start();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) dut.u_mem.mem[i] <= m_mem[i];
        m_pc = 4'd0; m_acc = 8'd0; m_out = 8'd0;
        m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step_instr(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
            end
            model_step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        @(negedge clk);
        tests++;
        if ({icycle, pc, acc, ir, out_port, zero, carry, halted} !== 35'd0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0",
                     {icycle, pc, acc, ir, out_port, zero, carry, halted});
        end
    endtask

    task automatic test_nop_wrap();
        logic [1:0] exp_ic;
        clear_image();
        start();
        for (int k = 0; k < 17; k++) begin
            for (int c = 0; c < 3; c++) begin
                exp_ic = 2'(c);
                tests++;
                if (icycle !== exp_ic) begin
                    fails++;
                    $display("FAIL nop_icycle: instr %0d got %0d expected %0d", k, icycle, exp_ic);
                end
                @(posedge clk);
                @(negedge clk);
            end
            model_step();
            tests++;
            if (pc !== m_pc) begin
                fails++;
                $display("FAIL nop_pc: instr %0d got %0d expected %0d", k, pc, m_pc);
            end
        end
        tests++;
        if (pc !== 4'd1) begin
            fails++;
            $display("FAIL nop_wrap: got %0d expected 1", pc);
        end
    endtask

    task automatic test_add_carry();
        clear_image();
        m_mem[0] = 8'h55; m_mem[1] = 8'h2F; m_mem[2] = 8'hE0; m_mem[3] = 8'hF0;
        m_mem[15] = 8'hFB;
        start();
        step_instr(3);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        tests++;
        if ({icycle, halted} !== {2'd2, 1'b0}) begin
            fails++;
            $display("FAIL hlt_execute: got icycle %0d halted %0d expected 2 0", icycle, halted);
        end
        @(posedge clk);
        @(negedge clk);
        model_step();
        tests++;
        if ({icycle, halted} !== {2'd3, 1'b1}) begin
            fails++;
            $display("FAIL hlt_entry: got icycle %0d halted %0d expected 3 1", icycle, halted);
        end
        tests++;
        if ({out_port, carry, zero} !== {8'h00, 1'b1, 1'b1} || m_out !== 8'h00) begin
            fails++;
            $display("FAIL add_carry: got out %h c %0d z %0d expected 00 1 1", out_port, carry, zero);
        end
        step_instr(2);
        tests++;
        if ({icycle, halted, pc, acc} !== {2'd3, 1'b1, m_pc, m_acc} || m_pc !== 4'd4) begin
            fails++;
            $display("FAIL halt_hold: got icycle %0d pc %0d acc %h expected 3 4 00", icycle, pc, acc);
        end
    endtask

    task automatic test_sub_borrow_jc();
        clear_image();
        m_mem[0] = 8'h53; m_mem[1] = 8'h3E; m_mem[2] = 8'h80; m_mem[14] = 8'h04;
        start();
        step_instr(2);
        tests++;
        if ({acc, carry, zero} !== {8'hFF, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sub_borrow: got acc %h c %0d z %0d expected ff 1 0", acc, carry, zero);
        end
        step_instr(1);
        tests++;
        if (pc !== 4'd0 || m_pc !== 4'd0) begin
            fails++;
            $display("FAIL jc_taken: got pc %0d expected 0", pc);
        end
    endtask

    task automatic test_sta_lda_jz();
        clear_image();
        m_mem[0] = 8'h59; m_mem[1] = 8'h4D; m_mem[2] = 8'h1D; m_mem[3] = 8'hE0;
        m_mem[4] = 8'h72;
        start();
        step_instr(4);
        tests++;
        if ({dut.u_mem.mem[13], out_port, zero} !== {8'h09, 8'h09, 1'b0}) begin
            fails++;
            $display("FAIL sta_lda: got mem13 %h out %h z %0d expected 09 09 0",
                     dut.u_mem.mem[13], out_port, zero);
        end
        step_instr(1);
        tests++;
        if (pc !== 4'd5 || m_pc !== 4'd5) begin
            fails++;
            $display("FAIL jz_not_taken: got pc %0d expected 5", pc);
        end
    endtask

    task automatic test_reset_sta();
        clear_image();
        m_mem[0] = 8'h59; m_mem[1] = 8'h4D; m_mem[13] = 8'h33;
        start();
        step_instr(1);
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (icycle !== 2'd1) begin
            fails++;
            $display("FAIL sta_decode_phase: got %0d expected 1", icycle);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({icycle, pc, acc, ir, out_port, zero, carry, halted} !== 35'd0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0",
                     {icycle, pc, acc, ir, out_port, zero, carry, halted});
        end
        repeat (3) @(negedge clk);
        tests++;
        if (dut.u_mem.mem[13] !== 8'h33) begin
            fails++;
            $display("FAIL reset_decode_sta: got mem13 %h expected 33", dut.u_mem.mem[13]);
        end
        start();
        step_instr(1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (dut.u_mem.mem[13] !== 8'h33 || pc !== 4'd0 || icycle !== 2'd0) begin
            fails++;
            $display("FAIL reset_execute_sta: got mem13 %h pc %0d icycle %0d expected 33 0 0",
                     dut.u_mem.mem[13], pc, icycle);
        end
    endtask

    task automatic test_run_length();
        clear_image();
        start();
        #100;
        tests++;
        if ({pc, icycle} !== {4'd3, 2'd1}) begin
            fails++;
            $display("FAIL run_length: got pc %0d icycle %0d expected 3 1", pc, icycle);
        end
    endtask

    task automatic test_random();
        logic [1:0] exp_ic;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'($urandom_range(0, 255));
            start();
            for (int k = 0; k < 24; k++) begin
                for (int c = 0; c < 3; c++) begin
                    exp_ic = m_halt ? 2'd3 : 2'(c);
                    tests++;
                    if (icycle !== exp_ic) begin
                        fails++;
                        $display("FAIL rand_icycle: prog %0d instr %0d got %0d expected %0d",
                                 p, k, icycle, exp_ic);
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                model_step();
                tests++;
                if ({pc, acc, out_port, zero, carry, halted} !==
                    {m_pc, m_acc, m_out, m_z, m_c, m_halt}) begin
                    fails++;
                    $display("FAIL rand_state: prog %0d instr %0d got pc %0d acc %h out %h z%0d c%0d h%0d expected pc %0d acc %h out %h z%0d c%0d h%0d",
                             p, k, pc, acc, out_port, zero, carry, halted,
                             m_pc, m_acc, m_out, m_z, m_c, m_halt);
                end
            end
            for (int i = 0; i < 16; i++) begin
                tests++;
                if (dut.u_mem.mem[i] !== m_mem[i]) begin
                    fails++;
                    $display("FAIL rand_mem: prog %0d addr %0d got %h expected %h",
                             p, i, dut.u_mem.mem[i], m_mem[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop_wrap();
        test_add_carry();
        test_sub_borrow_jc();
        test_sta_lda_jz();
        test_reset_sta();
        test_run_length();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
